// File: rtl/keypad_pkg.sv
// Shared types and key-map helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN       = 2'd0,
    ST_DEBOUNCE   = 2'd1,
    ST_HELD       = 2'd2,
    ST_RELEASE_DB = 2'd3
  } kp_state_t;

  localparam logic [3:0] COLS_IDLE = 4'b1111;

  // Legend printed on the keypad, addressed by driven row and low column.
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'd0:  code = 4'h1;
      4'd1:  code = 4'h2;
      4'd2:  code = 4'h3;
      4'd3:  code = 4'hA;
      4'd4:  code = 4'h4;
      4'd5:  code = 4'h5;
      4'd6:  code = 4'h6;
      4'd7:  code = 4'hB;
      4'd8:  code = 4'h7;
      4'd9:  code = 4'h8;
      4'd10: code = 4'h9;
      4'd11: code = 4'hC;
      4'd12: code = 4'hE;
      4'd13: code = 4'h0;
      4'd14: code = 4'hF;
      default: code = 4'hD;
    endcase
    return code;
  endfunction

  function automatic logic one_low(input logic [3:0] c);
    return ($countones(~c) == 1);
  endfunction

  function automatic logic [1:0] low_index(input logic [3:0] c);
    logic [1:0] idx;
    if (!c[0])      idx = 2'd0;
    else if (!c[1]) idx = 2'd1;
    else if (!c[2]) idx = 2'd2;
    else            idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Free-running divider producing a one-clk tick every SCAN_DIV cycles.
module scan_timer #(
  parameter int SCAN_DIV = 12000
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (cnt == LAST)  cnt <= '0;
    else                   cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/keypad_ctrl.sv
// Matrix keypad scanner: drives rows, debounces press and release, reports keys.
module keypad_ctrl
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 12000,
  parameter int DB_TICKS = 20
) (
  input  logic      clk,
  input  logic      reset,
  input  logic [3:0] cols,
  output logic [3:0] rows,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old,
  output kp_state_t  state_dbg
);

  localparam int DW = (DB_TICKS > 1) ? $clog2(DB_TICKS + 1) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_TICKS);

  logic [3:0]    sync1, scols;
  logic          tick;
  kp_state_t     state, state_n;
  logic [1:0]    row_idx, row_n;
  logic [3:0]    latch_cols, latch_n;
  logic [DW-1:0] db_cnt, cnt_n, cnt_inc;
  logic          accept;
  logic [3:0]    new_code;

  scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  assign cnt_inc  = db_cnt + 1'b1;
  assign new_code = key_lookup(row_idx, low_index(latch_cols));

  // key_valid is a one-cycle strobe with no back-pressure; key_code and the
  // digit pair hold their values until the next accepted press.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1      <= COLS_IDLE;
      scols      <= COLS_IDLE;
      state      <= ST_SCAN;
      row_idx    <= 2'd0;
      latch_cols <= COLS_IDLE;
      db_cnt     <= '0;
      key_valid  <= 1'b0;
      key_code   <= 4'h0;
      digit_new  <= 4'h0;
      digit_old  <= 4'h0;
    end else begin
      sync1      <= cols;
      scols      <= sync1;
      state      <= state_n;
      row_idx    <= row_n;
      latch_cols <= latch_n;
      db_cnt     <= cnt_n;
      key_valid  <= accept;
      if (accept) begin
        key_code  <= new_code;
        digit_new <= new_code;
        digit_old <= digit_new;
      end
    end
  end

  always_comb begin
    state_n = state;
    row_n   = row_idx;
    latch_n = latch_cols;
    cnt_n   = db_cnt;
    accept  = 1'b0;
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (one_low(scols)) begin
            latch_n = scols;
            cnt_n   = '0;
            state_n = ST_DEBOUNCE;
          end else begin
            row_n = row_idx + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (scols == latch_cols) begin
            cnt_n = cnt_inc;
            if (cnt_inc == DB_LAST) begin
              state_n = ST_HELD;
              accept  = 1'b1;
            end
          end else begin
            state_n = ST_SCAN;
            row_n   = row_idx + 2'd1;
          end
        end
        ST_HELD: begin
          if (scols == COLS_IDLE) begin
            cnt_n   = '0;
            state_n = ST_RELEASE_DB;
          end
        end
        ST_RELEASE_DB: begin
          if (scols == COLS_IDLE) begin
            if (cnt_inc == DB_LAST) begin
              cnt_n   = '0;
              state_n = ST_SCAN;
              row_n   = row_idx + 2'd1;
            end else begin
              cnt_n = cnt_inc;
            end
          end else begin
            state_n = ST_HELD;
          end
        end
        default: state_n = ST_SCAN;
      endcase
    end
  end

  always_comb begin
    rows      = ~(4'b0001 << row_idx);
    state_dbg = state;
  end

endmodule

// File: tb/tb_keypad_ctrl.sv
// Directed and randomized bench for keypad_ctrl with a physical keypad model.
module tb_keypad_ctrl;
  import keypad_pkg::*;

  localparam int SCAN_DIV = 4;
  localparam int DB_TICKS = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] cols;
  logic [3:0] rows;
  logic       key_valid;
  logic [3:0] key_code, digit_new, digit_old;
  kp_state_t  state_dbg;

  keypad_ctrl #(.SCAN_DIV(SCAN_DIV), .DB_TICKS(DB_TICKS)) dut (
    .clk      (clk),
    .reset    (reset),
    .cols     (cols),
    .rows     (rows),
    .key_valid(key_valid),
    .key_code (key_code),
    .digit_new(digit_new),
    .digit_old(digit_old),
    .state_dbg(state_dbg)
  );

  // clock / watchdog
  always #5 clk = ~clk;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // physical keypad: a pressed switch shorts its row to its column
  logic       pressed = 1'b0;
  logic [1:0] prow = 2'd0, pcol = 2'd0;
  logic       force_en = 1'b0;
  logic [3:0] force_val = 4'b1111;

  always_comb begin
    cols = 4'b1111;
    if (force_en) cols = force_val;
    else if (pressed && rows == ~(4'b0001 << prow)) cols = ~(4'b0001 << pcol);
  end

  // reference model: printed legend and the ordered list of accepted keys
  logic [3:0] kmap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                            4'h4, 4'h5, 4'h6, 4'hB,
                            4'h7, 4'h8, 4'h9, 4'hC,
                            4'hE, 4'h0, 4'hF, 4'hD};
  logic [3:0] exp_q[$];
  int exp_pulses = 0;
  int pulse_cnt = 0;
  int n_pass = 0, n_fail = 0, n_total = 0;

  always @(negedge clk) if (key_valid === 1'b1) pulse_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] row_drive(input int r);
    logic [3:0] one;
    one = 4'b0001;
    return ~(one << (r % 4));
  endfunction

  task automatic wait_ticks(input int n);
    repeat (n * SCAN_DIV) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic press_key(input int r, input int c, input int hold_t, input int rel_t);
    @(negedge clk);
    prow = 2'(r);
    pcol = 2'(c);
    pressed = 1'b1;
    wait_ticks(hold_t);
    pressed = 1'b0;
    wait_ticks(rel_t);
  endtask

  task automatic accept_key(input int r, input int c);
    exp_q.push_back(kmap[r * 4 + c]);
    exp_pulses++;
  endtask

  task automatic check_model(input string tag);
    logic [3:0] en, eo;
    en = (exp_q.size() > 0) ? exp_q[exp_q.size() - 1] : 4'h0;
    eo = (exp_q.size() > 1) ? exp_q[exp_q.size() - 2] : 4'h0;
    check({tag, "_pulses"}, pulse_cnt, exp_pulses);
    check({tag, "_key_code"}, key_code, en);
    check({tag, "_digit_new"}, digit_new, en);
    check({tag, "_digit_old"}, digit_old, eo);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rows"}, rows, 4'b1110);
    check({tag, "_key_valid"}, key_valid, 1'b0);
    check({tag, "_key_code"}, key_code, 4'h0);
    check({tag, "_digit_new"}, digit_new, 4'h0);
    check({tag, "_digit_old"}, digit_old, 4'h0);
  endtask

  initial begin
    int first;
    int p0;
    int r, c, g;
    logic [3:0] r0;

    // reset values
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("reset_state", state_dbg, ST_SCAN);

    // idle scan: first tick SCAN_DIV cycles after release, then rotation
    reset = 1'b1;
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      @(posedge clk);
      #1;
      if (rows !== 4'b1110) first = i;
    end
    check("first_tick_latency", first, SCAN_DIV);
    for (int k = 0; k < 8; k++) begin
      check("idle_rows", rows, row_drive(k + 1));
      repeat (SCAN_DIV) @(posedge clk);
      #1;
    end
    check("idle_no_pulse", pulse_cnt, 0);

    // long hold of key 6 gives exactly one report
    press_key(1, 2, 20, 8);
    accept_key(1, 2);
    check_model("hold6");

    // 5 then 0
    press_key(1, 1, 12, 8);
    accept_key(1, 1);
    check_model("press5");
    press_key(3, 1, 12, 8);
    accept_key(3, 1);
    check_model("press0");

    // one-tick bounce
    @(negedge clk);
    force_val = 4'b1011;
    force_en = 1'b1;
    repeat (SCAN_DIV) @(negedge clk);
    force_en = 1'b0;
    wait_ticks(3);
    check("bounce_state", state_dbg, ST_SCAN);
    check("bounce_pulses", pulse_cnt, exp_pulses);
    r0 = rows;
    repeat (SCAN_DIV) @(negedge clk);
    check("bounce_row_adv", rows, {r0[2:0], r0[3]});

    // two columns low is not a press
    force_val = 4'b1001;
    force_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      r0 = rows;
      repeat (SCAN_DIV) @(negedge clk);
      check("multi_row_adv", rows, {r0[2:0], r0[3]});
    end
    force_en = 1'b0;
    wait_ticks(2);
    check("multi_pulses", pulse_cnt, exp_pulses);
    check("multi_state", state_dbg, ST_SCAN);

    // reset during HELD
    p0 = pulse_cnt;
    @(negedge clk);
    prow = 2'd2;
    pcol = 2'd2;
    pressed = 1'b1;
    for (int i = 0; i < 200 && pulse_cnt == p0; i++) @(negedge clk);
    check("held_accept", pulse_cnt - p0, 1);
    accept_key(2, 2);
    wait_ticks(2);
    check("held_state", state_dbg, ST_HELD);
    reset = 1'b0;
    #1;
    check_reset_outputs("mid_hold_reset");
    pressed = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    wait_ticks(8);
    check_model("after_reset");
    press_key(2, 2, 12, 8);
    accept_key(2, 2);
    check_model("repress9");

    // randomized presses with short glitches between them
    for (int n = 0; n < 8; n++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      press_key(r, c, $urandom_range(12, 18), $urandom_range(8, 12));
      accept_key(r, c);
      check_model("rand_press");
      g = $urandom_range(1, 8);
      @(negedge clk);
      prow = 2'($urandom_range(0, 3));
      pcol = 2'($urandom_range(0, 3));
      pressed = 1'b1;
      repeat (g) @(negedge clk);
      pressed = 1'b0;
      wait_ticks(3);
      check("rand_glitch_pulses", pulse_cnt, exp_pulses);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
